uart_ram_cmd_ctrl: RTL and testbench

//  Command sequencer between the UART byte receiver and the on-chip RAM. Parses received

---
 rtl/uart_ram_cmd_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_ram_cmd_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_cmd_ctrl.sv
// Purpose: parse UART bytes into 'W',addr,data / 'R',addr frames, drive the RAM port, return read data.
// Latency: ram_we the cycle after the data byte; tx_start RD_LAT+2 cycles after the read address byte.
// Backpressure: holds TX_REQ while tx_busy is high; bytes arriving while not accepting set err_overrun.
module uart_ram_cmd_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              CLOCK_50,
  input  logic              Reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_cmd
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, W_ADDR, W_DATA, WRITE, R_ADDR, R_WAIT, TX_REQ
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TW-1:0]     r_to_cnt;
  logic [1:0]        r_lat_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_tx_data;
  logic              r_err_overrun;
  logic              r_err_cmd;
  logic              w_to_run;
  logic              w_timeout;
  logic              w_lat_done;
  logic              w_bad_cmd;
  logic              w_overrun;

  // Inter-byte timeout only matters while a frame is partially received.
  assign w_to_run   = (r_state == W_ADDR) || (r_state == W_DATA) || (r_state == R_ADDR);
  assign w_timeout  = w_to_run && !rx_valid && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_lat_done = (r_state == R_WAIT) && (r_lat_cnt == 2'(RD_LAT));
  assign w_bad_cmd  = (r_state == IDLE) && rx_valid && (rx_data != 8'h57) && (rx_data != 8'h52);
  assign w_overrun  = rx_valid && ((r_state == WRITE) || (r_state == R_WAIT) || (r_state == TX_REQ));

  // State register.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (rx_valid && rx_data == 8'h57)      w_state_nxt = W_ADDR;
        else if (rx_valid && rx_data == 8'h52) w_state_nxt = R_ADDR;
      end
      W_ADDR: begin
        if (rx_valid)       w_state_nxt = W_DATA;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      W_DATA: begin
        if (rx_valid)       w_state_nxt = WRITE;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      WRITE:  w_state_nxt = IDLE;
      R_ADDR: begin
        if (rx_valid)       w_state_nxt = R_WAIT;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      R_WAIT: if (w_lat_done) w_state_nxt = TX_REQ;
      TX_REQ: if (!tx_busy)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Timeout counter: restarts on every received byte and on any state change.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n)                                           r_to_cnt <= '0;
    else if (w_to_run && !rx_valid && w_state_nxt == r_state) r_to_cnt <= r_to_cnt + 1'b1;
    else                                                    r_to_cnt <= '0;
  end

  // Read latency counter: counts from 0 on R_WAIT entry; capture happens once it reaches RD_LAT.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n)              r_lat_cnt <= '0;
    else if (r_state == R_WAIT) r_lat_cnt <= r_lat_cnt + 1'b1;
    else                       r_lat_cnt <= '0;
  end

  // Datapath latches; address and write data hold their last value between frames.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx_data <= '0;
    end else begin
      if (rx_valid && (r_state == W_ADDR || r_state == R_ADDR)) r_addr <= rx_data[ADDR_W-1:0];
      if (rx_valid && r_state == W_DATA) r_wdata <= rx_data;
      if (w_lat_done) r_tx_data <= ram_rdata;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_err_overrun <= 1'b0;
      r_err_cmd     <= 1'b0;
    end else begin
      if (w_overrun)             r_err_overrun <= 1'b1;
      if (w_bad_cmd || w_timeout) r_err_cmd    <= 1'b1;
    end
  end

  assign ram_addr    = r_addr;
  assign ram_wdata   = r_wdata;
  assign ram_we      = (r_state == WRITE);
  assign tx_start    = (r_state == TX_REQ) && !tx_busy;
  assign tx_data     = r_tx_data;
  assign busy        = (r_state != IDLE);
  assign err_overrun = r_err_overrun;
  assign err_cmd     = r_err_cmd;

endmodule

// File: tb/tb_uart_ram_cmd_ctrl.sv
// Directed bench for uart_ram_cmd_ctrl with a 1-cycle synchronous RAM model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// A short timeout is used so the abort path is reachable quickly.
module tb_uart_ram_cmd_ctrl;

  localparam int ADDR_W = 5;
  localparam int RD_LAT = 1;
  localparam int TO_CYC = 50;

  logic              CLOCK_50 = 1'b0;
  logic              Reset_n  = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data  = 8'h00;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic [7:0]        ram_rdata;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy  = 1'b0;
  logic              busy;
  logic              err_overrun;
  logic              err_cmd;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int tx_cnt = 0;
  int we_base;
  int tx_base;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] r_rd;

  uart_ram_cmd_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .TIMEOUT_CYC(TO_CYC)) dut (
    .CLOCK_50(CLOCK_50), .Reset_n(Reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy),
    .err_overrun(err_overrun), .err_cmd(err_cmd)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // RAM model with one clock of read latency, plus pulse counters.
  initial for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 8'h00;
  always @(posedge CLOCK_50) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    r_rd <= mem[ram_addr];
    if (ram_we)   we_cnt <= we_cnt + 1;
    if (tx_start) tx_cnt <= tx_cnt + 1;
  end
  assign ram_rdata = r_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLOCK_50); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge CLOCK_50); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50); #1;
    Reset_n = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    Reset_n = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLOCK_50);
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_txs", tx_start, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_ovr", err_overrun, 0);
    chk("rst_cmd", err_cmd, 0);
    Reset_n = 1'b1;
    idle_cycles(2);

    // 1: write A5 to address 3
    we_base = we_cnt;
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
    @(negedge CLOCK_50);
    chk("t1_we", ram_we, 1);
    chk("t1_addr", ram_addr, 5'h03);
    chk("t1_wdata", ram_wdata, 8'hA5);
    idle_cycles(3);
    chk("t1_we_once", we_cnt - we_base, 1);
    chk("t1_busy", busy, 0);
    chk("t1_mem", mem[3], 8'hA5);

    // 2: read address 3, tx_start exactly RD_LAT+2 cycles after the address byte
    tx_base = tx_cnt;
    send_byte(8'h52); send_byte(8'h03);
    @(negedge CLOCK_50); chk("t2_txs_c1", tx_start, 0);
    @(negedge CLOCK_50); chk("t2_txs_c2", tx_start, 0);
    @(negedge CLOCK_50); chk("t2_txs_c3", tx_start, 1);
    chk("t2_txd", tx_data, 8'hA5);
    idle_cycles(3);
    chk("t2_tx_once", tx_cnt - tx_base, 1);
    chk("t2_busy", busy, 0);

    // 4: write frame abandoned after the timeout; 3C is never written
    do_reset();
    we_base = we_cnt;
    send_byte(8'h57); send_byte(8'h04);
    repeat (TO_CYC - 1) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("t4_busy_pre", busy, 1);
    chk("t4_cmd_pre", err_cmd, 0);
    @(negedge CLOCK_50);
    chk("t4_busy_post", busy, 0);
    chk("t4_cmd_post", err_cmd, 1);
    send_byte(8'h3C);
    idle_cycles(3);
    chk("t4_no_we", we_cnt - we_base, 0);
    chk("t4_mem", mem[4], 8'h00);
    chk("t4_idle", busy, 0);

    // 3: unknown command then a normal write
    do_reset();
    we_base = we_cnt;
    tx_base = tx_cnt;
    send_byte(8'h41);
    @(negedge CLOCK_50);
    chk("t3_cmd", err_cmd, 1);
    chk("t3_busy", busy, 0);
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h11);
    @(negedge CLOCK_50);
    chk("t3_we", ram_we, 1);
    chk("t3_addr", ram_addr, 5'h01);
    chk("t3_wdata", ram_wdata, 8'h11);
    idle_cycles(3);
    chk("t3_we_once", we_cnt - we_base, 1);
    chk("t3_no_tx", tx_cnt - tx_base, 0);
    chk("t3_mem", mem[1], 8'h11);

    // 5: read held off by tx_busy, with an overrun byte during the wait
    do_reset();
    send_byte(8'h57); send_byte(8'h02); send_byte(8'hC3);
    idle_cycles(2);
    tx_base = tx_cnt;
    tx_busy = 1'b1;
    send_byte(8'h52); send_byte(8'h02);
    idle_cycles(10);
    chk("t5_ovr_pre", err_overrun, 0);
    send_byte(8'h57);
    @(negedge CLOCK_50);
    chk("t5_ovr", err_overrun, 1);
    repeat (488) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("t5_hold_busy", busy, 1);
    chk("t5_no_tx", tx_cnt - tx_base, 0);
    chk("t5_txs_low", tx_start, 0);
    @(posedge CLOCK_50); #1;
    tx_busy = 1'b0;
    @(negedge CLOCK_50);
    chk("t5_txs", tx_start, 1);
    chk("t5_txd", tx_data, 8'hC3);
    idle_cycles(3);
    chk("t5_tx_once", tx_cnt - tx_base, 1);
    chk("t5_idle", busy, 0);
    chk("t5_cmd", err_cmd, 0);

    // 6: address truncation, then reset in the middle of a frame
    do_reset();
    we_base = we_cnt;
    tx_base = tx_cnt;
    send_byte(8'h57); send_byte(8'hFF);
    @(negedge CLOCK_50);
    chk("t6_addr", ram_addr, 5'h1F);
    chk("t6_busy", busy, 1);
    @(posedge CLOCK_50); #1;
    Reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", ram_addr, 0);
    chk("t6_rst_we", ram_we, 0);
    @(negedge CLOCK_50);
    Reset_n = 1'b1;
    send_byte(8'h77);
    idle_cycles(5);
    chk("t6_no_we", we_cnt - we_base, 0);
    chk("t6_no_tx", tx_cnt - tx_base, 0);
    chk("t6_mem", mem[31], 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
